bus_arbiter3: RTL and testbench

- Shares one femto slave bus (ROM/RAM controller side) among three masters: m0 = instruction fetch, m1 = data load/store, m2 = debug/DMA.
- Arbitration is round-robin.
- Each master has a one-deep request capture register, so a req pulse is never lost while the slave is busy.
- A watchdog forces a fault response if the slave hangs.
- Sits between core/debug bus masters and a single-port slave controller; a three-master generalisation of the platform's slave-sharing layer.

---
 rtl/femto_bus_pkg.sv | 43 ++++
 rtl/rr_pick3.sv | 27 ++
 rtl/bus_arbiter3.sv | 163 ++++++++++++++++
 tb/tb_bus_arbiter3.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_bus_pkg.sv
// Shared types and widths for the femto bus slave-sharing layer.
// Bus geometry macros default here when the platform does not supply them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

package femto_bus_pkg;

    localparam int XLEN_W = `XLEN;
    localparam int BUS_W  = `BUS_WIDTH;
    localparam int ACC_W  = $clog2(`BUS_ACC_CNT);

    localparam logic [1:0] MST_I = 2'd0;
    localparam logic [1:0] MST_D = 2'd1;
    localparam logic [1:0] MST_X = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [XLEN_W-1:0] addr;
        logic              w_rb;
        logic [ACC_W-1:0]  acc;
        logic [BUS_W-1:0]  wdata;
    } bus_req_t;

    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        onehot3_to_idx = oh[2] ? MST_X : (oh[1] ? MST_D : MST_I);
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        next_ptr = (idx == MST_X) ? MST_I : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first candidate at or after ptr_i, modulo 3.
module rr_pick3 (
    input  logic [2:0] cand_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grant_o,
    output logic       valid_o
);

    logic [1:0] idx;

    // NOTE: combinational blocks use blocking assignments and give every output
    // a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        // Scan from farthest to nearest so the nearest candidate overwrites last.
        for (int i = 2; i >= 0; i--) begin
            idx = 2'((int'(ptr_i) + i) % 3);
            if (cand_i[idx]) begin
                grant_o = 3'b001 << idx;
            end
        end
    end

    assign valid_o = |cand_i;

endmodule

// File: rtl/bus_arbiter3.sv
// Three-master round-robin arbiter onto one femto slave bus, with per-master
// one-deep request capture and a response watchdog.
module bus_arbiter3
    import femto_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3*XLEN_W-1:0] m_addr_i,
    input  logic [2:0]          m_w_rb_i,
    input  logic [3*ACC_W-1:0]  m_acc_i,
    input  logic [3*BUS_W-1:0]  m_wdata_i,
    input  logic [2:0]          m_req_i,
    output logic [BUS_W-1:0]    m_rdata_o,
    output logic [2:0]          m_resp_o,
    output logic [2:0]          m_fault_o,
    output logic [XLEN_W-1:0]   s_addr_o,
    output logic                s_w_rb_o,
    output logic [ACC_W-1:0]    s_acc_o,
    output logic [BUS_W-1:0]    s_wdata_o,
    output logic                s_req_o,
    input  logic [BUS_W-1:0]    s_rdata_i,
    input  logic                s_resp_i,
    input  logic                s_fault_i
);

    localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       pend_q, pend_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             tmo_q, tmo_d;
    logic             s_req_q, s_req_d;
    bus_req_t         s_fields_q, s_fields_d;
    bus_req_t         pend_req_q [3];
    bus_req_t         m_in [3];

    logic [2:0] owner_oh;
    logic [2:0] busy_mask;
    logic [2:0] acc_req;
    logic [2:0] cand;
    logic [2:0] grant_oh;
    logic       grant_vld;
    logic [1:0] grant_idx;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            m_in[k].addr  = m_addr_i[k*XLEN_W +: XLEN_W];
            m_in[k].w_rb  = m_w_rb_i[k];
            m_in[k].acc   = m_acc_i[k*ACC_W +: ACC_W];
            m_in[k].wdata = m_wdata_i[k*BUS_W +: BUS_W];
        end
    end

    // A master is outstanding from its grant until its response pulse, timeout pulse included.
    assign owner_oh  = 3'b001 << owner_q;
    assign busy_mask = (state_q == BUSY || tmo_q) ? owner_oh : 3'b000;
    assign acc_req   = m_req_i & ~pend_q & ~busy_mask;
    assign cand      = pend_q | acc_req;
    assign grant_idx = onehot3_to_idx(grant_oh);

    rr_pick3 u_pick (
        .cand_i  (cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_oh),
        .valid_o (grant_vld)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        pend_d     = pend_q | acc_req;
        wdog_d     = wdog_q;
        tmo_d      = 1'b0;
        s_req_d    = 1'b0;
        s_fields_d = s_fields_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    s_fields_d = pend_q[grant_idx] ? pend_req_q[grant_idx] : m_in[grant_idx];
                    s_req_d    = 1'b1;
                    owner_d    = grant_idx;
                    rr_ptr_d   = next_ptr(grant_idx);
                    pend_d     = pend_d & ~grant_oh;
                    wdog_d     = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // A real response beats a watchdog expiry landing in the same cycle.
                if (s_resp_i) begin
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && wdog_q == WDOG_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= MST_I;
            rr_ptr_q   <= MST_I;
            pend_q     <= '0;
            wdog_q     <= '0;
            tmo_q      <= 1'b0;
            s_req_q    <= 1'b0;
            s_fields_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            pend_q     <= pend_d;
            wdog_q     <= wdog_d;
            tmo_q      <= tmo_d;
            s_req_q    <= s_req_d;
            s_fields_q <= s_fields_d;
        end
    end

    // NOTE: the capture payload is not reset; it is only read while its pend bit
    // is set, and that bit is reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (acc_req[k]) begin
                pend_req_q[k] <= m_in[k];
            end
        end
    end

    always_comb begin
        m_resp_o  = '0;
        m_fault_o = '0;
        m_rdata_o = '0;
        if (state_q == BUSY && s_resp_i) begin
            m_resp_o  = owner_oh;
            m_fault_o = s_fault_i ? owner_oh : 3'b000;
            m_rdata_o = s_rdata_i;
        end else if (tmo_q) begin
            m_resp_o  = owner_oh;
            m_fault_o = owner_oh;
        end
    end

    assign s_req_o   = s_req_q;
    assign s_addr_o  = s_fields_q.addr;
    assign s_w_rb_o  = s_fields_q.w_rb;
    assign s_acc_o   = s_fields_q.acc;
    assign s_wdata_o = s_fields_q.wdata;

endmodule

// File: tb/tb_bus_arbiter3.sv
// Directed bench for bus_arbiter3: reset, contention, round-robin, watchdog,
// mid-transaction reset and dropped duplicate requests.
module tb_bus_arbiter3;
    import femto_bus_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [3*XLEN_W-1:0] m_addr;
    logic [2:0]          m_w_rb;
    logic [3*ACC_W-1:0]  m_acc;
    logic [3*BUS_W-1:0]  m_wdata;
    logic [2:0]          m_req;
    logic [BUS_W-1:0]    m_rdata;
    logic [2:0]          m_resp;
    logic [2:0]          m_fault;
    logic [XLEN_W-1:0]   s_addr;
    logic                s_w_rb;
    logic [ACC_W-1:0]    s_acc;
    logic [BUS_W-1:0]    s_wdata;
    logic                s_req;
    logic [BUS_W-1:0]    s_rdata;
    logic                s_resp;
    logic                s_fault;

    int checks = 0;
    int passes = 0;

    bus_arbiter3 #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr_i  (m_addr),
        .m_w_rb_i  (m_w_rb),
        .m_acc_i   (m_acc),
        .m_wdata_i (m_wdata),
        .m_req_i   (m_req),
        .m_rdata_o (m_rdata),
        .m_resp_o  (m_resp),
        .m_fault_o (m_fault),
        .s_addr_o  (s_addr),
        .s_w_rb_o  (s_w_rb),
        .s_acc_o   (s_acc),
        .s_wdata_o (s_wdata),
        .s_req_o   (s_req),
        .s_rdata_i (s_rdata),
        .s_resp_i  (s_resp),
        .s_fault_i (s_fault)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic [XLEN_W-1:0] addr, input logic wrb,
                         input logic [ACC_W-1:0] acc, input logic [BUS_W-1:0] wdata);
        m_addr[k*XLEN_W +: XLEN_W] = addr;
        m_w_rb[k]                  = wrb;
        m_acc[k*ACC_W +: ACC_W]    = acc;
        m_wdata[k*BUS_W +: BUS_W]  = wdata;
    endtask

    // Waits for s_req, checks its fields, responds two cycles later and checks routing.
    task automatic serve_one(input logic [XLEN_W-1:0] ea, input logic ew, input logic [ACC_W-1:0] eacc,
                             input logic [BUS_W-1:0] ewd, input logic [2:0] eresp,
                             input logic [BUS_W-1:0] rd, input logic flt, output int n);
        bit found = 0;
        n = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            if (s_req) found = 1;
            else begin
                step();
                n++;
            end
        end
        checks++;
        if (!found) begin
            $display("FAIL serve_wait: no s_req within 20 cycles, want addr %h", ea);
            return;
        end
        passes++;
        checks++;
        if (s_addr !== ea) $display("FAIL serve_addr: got %h want %h", s_addr, ea);
        else passes++;
        checks++;
        if ({s_w_rb, s_acc, s_wdata} !== {ew, eacc, ewd})
            $display("FAIL serve_fields: got w_rb=%b acc=%0d wdata=%h want w_rb=%b acc=%0d wdata=%h",
                     s_w_rb, s_acc, s_wdata, ew, eacc, ewd);
        else passes++;
        step();
        step();
        s_resp  = 1'b1;
        s_rdata = rd;
        s_fault = flt;
        @(negedge clk);
        checks++;
        if (m_resp !== eresp) $display("FAIL serve_resp: got %b want %b", m_resp, eresp);
        else passes++;
        checks++;
        if (m_rdata !== rd) $display("FAIL serve_rdata: got %h want %h", m_rdata, rd);
        else passes++;
        checks++;
        if (m_fault !== (flt ? eresp : 3'b000))
            $display("FAIL serve_fault: got %b want %b", m_fault, flt ? eresp : 3'b000);
        else passes++;
        step();
        s_resp  = 1'b0;
        s_rdata = '0;
        s_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_addr  = '0;
        m_w_rb  = '0;
        m_acc   = '0;
        m_wdata = '0;
        m_req   = '0;
        s_rdata = '0;
        s_resp  = 1'b0;
        s_fault = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({s_req, s_addr, s_w_rb, s_acc, s_wdata} !== '0)
            $display("FAIL reset_slave_side: got req=%b addr=%h wdata=%h want all 0", s_req, s_addr, s_wdata);
        else passes++;
        checks++;
        if ({m_resp, m_fault, m_rdata} !== '0)
            $display("FAIL reset_master_side: got resp=%b fault=%b rdata=%h want all 0", m_resp, m_fault, m_rdata);
        else passes++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_contention();
        int n;
        set_m(0, 32'h10, 1'b0, 2'd0, 32'h0);
        set_m(1, 32'h20, 1'b0, 2'd1, 32'h0);
        set_m(2, 32'h30, 1'b1, 2'd2, 32'h2222_2222);
        m_req = 3'b111;
        step();
        m_req = 3'b000;
        serve_one(32'h10, 1'b0, 2'd0, 32'h0, 3'b001, 32'hA0A0_0001, 1'b0, n);
        checks++;
        if (n !== 0) $display("FAIL contention_first_latency: got %0d want 0", n);
        else passes++;
        serve_one(32'h20, 1'b0, 2'd1, 32'h0, 3'b010, 32'hA0A0_0002, 1'b0, n);
        checks++;
        if (n + 1 !== 2) $display("FAIL contention_gap_1: got %0d want 2", n + 1);
        else passes++;
        serve_one(32'h30, 1'b1, 2'd2, 32'h2222_2222, 3'b100, 32'hA0A0_0003, 1'b0, n);
        checks++;
        if (n + 1 !== 2) $display("FAIL contention_gap_2: got %0d want 2", n + 1);
        else passes++;
    endtask

    task automatic test_rr_pointer();
        int n;
        set_m(0, 32'h40, 1'b0, 2'd0, 32'h0);
        set_m(2, 32'h60, 1'b0, 2'd0, 32'h0);
        m_req = 3'b101;
        step();
        m_req = 3'b000;
        serve_one(32'h40, 1'b0, 2'd0, 32'h0, 3'b001, 32'h0000_0040, 1'b0, n);
        serve_one(32'h60, 1'b0, 2'd0, 32'h0, 3'b100, 32'h0000_0060, 1'b0, n);
    endtask

    task automatic test_single_read();
        set_m(1, 32'h0000_0100, 1'b0, 2'd2, 32'h0);
        m_req = 3'b010;
        step();
        m_req = 3'b000;
        @(negedge clk);
        checks++;
        if ({s_req, s_addr, s_w_rb} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL single_sreq: got req=%b addr=%h w_rb=%b want req=1 addr=100 w_rb=0", s_req, s_addr, s_w_rb);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (s_req !== 1'b0) $display("FAIL single_sreq_pulse: got %b want 0", s_req);
        else passes++;
        step();
        s_resp  = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({m_resp, m_rdata} !== {3'b010, 32'hDEAD_BEEF})
            $display("FAIL single_resp: got resp=%b rdata=%h want 010 deadbeef", m_resp, m_rdata);
        else passes++;
        step();
        s_resp  = 1'b0;
        s_rdata = '0;
        @(negedge clk);
        checks++;
        if ({m_resp, m_rdata} !== '0)
            $display("FAIL single_idle_rdata: got resp=%b rdata=%h want 0", m_resp, m_rdata);
        else passes++;
        step();
    endtask

    task automatic test_watchdog();
        set_m(1, 32'h200, 1'b0, 2'd0, 32'h0);
        m_req = 3'b010;
        step();
        m_req = 3'b000;
        @(negedge clk);
        checks++;
        if (s_req !== 1'b1) $display("FAIL wdog_sreq: got %b want 1", s_req);
        else passes++;
        for (int i = 1; i <= 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (m_resp !== 3'b000) $display("FAIL wdog_early_%0d: got %b want 000", i, m_resp);
            else passes++;
        end
        step();
        @(negedge clk);
        checks++;
        if ({m_resp, m_fault, m_rdata} !== {3'b010, 3'b010, 32'h0})
            $display("FAIL wdog_fire: got resp=%b fault=%b rdata=%h want 010 010 0", m_resp, m_fault, m_rdata);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (m_resp !== 3'b000) $display("FAIL wdog_one_pulse: got %b want 000", m_resp);
        else passes++;
        step();
        s_resp  = 1'b1;
        s_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({m_resp, m_rdata} !== '0)
            $display("FAIL wdog_stale_resp: got resp=%b rdata=%h want 0", m_resp, m_rdata);
        else passes++;
        step();
        s_resp  = 1'b0;
        s_rdata = '0;
        step();
    endtask

    task automatic test_mid_reset();
        int n;
        int sreq_cnt = 0;
        set_m(0, 32'h80, 1'b1, 2'd1, 32'h8888_8888);
        m_req = 3'b001;
        step();
        set_m(2, 32'hA0, 1'b0, 2'd0, 32'h0);
        m_req = 3'b100;
        @(negedge clk);
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h80})
            $display("FAIL mreset_sreq: got req=%b addr=%h want 1 80", s_req, s_addr);
        else passes++;
        step();
        m_req = 3'b000;
        rst   = 1'b1;
        #1;
        checks++;
        if ({s_req, s_addr, s_w_rb, s_acc, s_wdata, m_resp, m_fault, m_rdata} !== '0)
            $display("FAIL mreset_outputs: got addr=%h wdata=%h resp=%b want all 0", s_addr, s_wdata, m_resp);
        else passes++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                s_resp  = 1'b1;
                s_rdata = 32'h5A5A_5A5A;
            end
            @(negedge clk);
            if (s_req) sreq_cnt++;
            if (i == 1) begin
                checks++;
                if (m_resp !== 3'b000) $display("FAIL mreset_stale_resp: got %b want 000", m_resp);
                else passes++;
            end
            step();
            s_resp  = 1'b0;
            s_rdata = '0;
        end
        checks++;
        if (sreq_cnt !== 0) $display("FAIL mreset_pend_cleared: got %0d s_req want 0", sreq_cnt);
        else passes++;
        set_m(2, 32'hC0, 1'b0, 2'd3, 32'h0);
        m_req = 3'b100;
        step();
        m_req = 3'b000;
        serve_one(32'hC0, 1'b0, 2'd3, 32'h0, 3'b100, 32'h0000_00C0, 1'b0, n);
    endtask

    task automatic test_protocol_violation();
        int n;
        int sreq_cnt = 0;
        set_m(1, 32'h500, 1'b0, 2'd0, 32'h0);
        m_req = 3'b010;
        step();
        set_m(0, 32'h300, 1'b1, 2'd2, 32'hCAFE_0000);
        m_req = 3'b001;
        @(negedge clk);
        checks++;
        if ({s_req, s_addr} !== {1'b1, 32'h500})
            $display("FAIL proto_m1_sreq: got req=%b addr=%h want 1 500", s_req, s_addr);
        else passes++;
        step();
        set_m(0, 32'h3F0, 1'b0, 2'd1, 32'h0000_0BAD);
        m_req = 3'b001;
        step();
        m_req   = 3'b000;
        s_resp  = 1'b1;
        s_rdata = 32'h0000_0055;
        @(negedge clk);
        checks++;
        if (m_resp !== 3'b010) $display("FAIL proto_m1_resp: got %b want 010", m_resp);
        else passes++;
        step();
        s_resp  = 1'b0;
        s_rdata = '0;
        serve_one(32'h300, 1'b1, 2'd2, 32'hCAFE_0000, 3'b001, 32'h0000_0066, 1'b1, n);
        checks++;
        if (n !== 1) $display("FAIL proto_m0_latency: got %0d want 1", n);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_req) sreq_cnt++;
            step();
        end
        checks++;
        if (sreq_cnt !== 0) $display("FAIL proto_dup_dropped: got %0d extra s_req want 0", sreq_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_rr_pointer();
        test_single_read();
        test_watchdog();
        test_mid_reset();
        test_protocol_violation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
